// File: rtl/boot_pkg.sv
// Shared types and constants for the boot/run controller.
package boot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } boot_state_t;

  localparam int CYC_W = 16;

endpackage

// File: rtl/run_watchdog.sv
// Run-cycle counter with saturation and optional budget expiry.
module run_watchdog
  import boot_pkg::*;
#(
  parameter int cyc_width = CYC_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_run,
  input  logic                 i_abort,
  input  logic [cyc_width-1:0] i_max,
  output logic [cyc_width-1:0] o_count,
  output logic                 o_expire
);

  logic [cyc_width-1:0] r_count;
  logic [cyc_width-1:0] r_max;
  logic                 w_budget;

  assign w_budget = (r_max != '0);
  assign o_expire = i_run && w_budget && (r_count == r_max - cyc_width'(1));
  assign o_count  = r_count;

  // An abort cycle is not counted unless it coincides with expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_max   <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_max   <= i_max;
    end else if (o_expire) begin
      r_count <= r_max;
    end else if (i_run && !i_abort && (r_count != '1)) begin
      r_count <= r_count + cyc_width'(1);
    end
  end

endmodule

// File: rtl/boot_ctrl.sv
// Boot controller: loads a host image into memory, then runs the core under a cycle budget.
module boot_ctrl
  import boot_pkg::*;
#(
  parameter  int word_width = 8,
  parameter  int cyc_width  = CYC_W,
  localparam int addr_width = $clog2(word_width)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_start,
  input  logic [addr_width:0]   host_len,
  input  logic                  host_abort,
  input  logic                  host_valid,
  input  logic [word_width-1:0] host_data,
  output logic                  host_ready,
  input  logic [cyc_width-1:0]  max_cycles,
  input  logic                  core_write,
  input  logic [addr_width-1:0] core_addr,
  input  logic [word_width-1:0] core_wdata,
  output logic                  core_reset,
  output logic                  mem_write,
  output logic [addr_width-1:0] mem_addr,
  output logic [word_width-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [cyc_width-1:0]  run_cycles
);

  localparam int LEN_W = addr_width + 1;
  localparam int DEPTH = 2 ** addr_width;

  // IDLE: core held, port idle | LOAD: host fills memory | RUN: core owns port | HALTED: core held, status valid
  boot_state_t           r_state;
  logic [LEN_W-1:0]      r_len;
  logic [addr_width-1:0] r_ptr;
  logic                  r_timeout;
  logic [LEN_W-1:0]      w_len_clamp;
  logic                  w_start_ok;
  logic                  w_run;
  logic                  w_expire;

  assign w_len_clamp = (int'(host_len) > DEPTH) ? LEN_W'(DEPTH) : host_len;
  assign w_start_ok  = host_start && ((r_state == IDLE) || (r_state == HALTED));
  assign w_run       = (r_state == RUN);

  run_watchdog #(.cyc_width(cyc_width)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start_ok),
    .i_run    (w_run),
    .i_abort  (host_abort),
    .i_max    (max_cycles),
    .o_count  (run_cycles),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_ptr     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (host_start) begin
            r_len     <= w_len_clamp;
            r_ptr     <= '0;
            r_timeout <= 1'b0;
            r_state   <= (w_len_clamp != '0) ? LOAD : RUN;
          end
        end
        LOAD: begin
          if (host_abort) begin
            r_state <= IDLE;
          end else if (host_valid) begin
            r_ptr <= r_ptr + addr_width'(1);
            if ({1'b0, r_ptr} == r_len - LEN_W'(1)) r_state <= RUN;
          end
        end
        RUN: begin
          if (w_expire) begin
            r_state   <= HALTED;
            r_timeout <= 1'b1;
          end else if (host_abort) begin
            r_state   <= HALTED;
            r_timeout <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      LOAD: begin
        mem_write = host_valid;
        mem_addr  = r_ptr;
        mem_wdata = host_data;
      end
      RUN: begin
        mem_write = core_write;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      default: ;
    endcase
  end

  assign host_ready = (r_state == LOAD);
  assign core_reset = (r_state != RUN);
  assign busy       = (r_state == LOAD) || (r_state == RUN);
  assign done       = (r_state == HALTED);
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_boot_ctrl.sv
// Scoreboard bench for boot_ctrl: expected memory writes are queued by stimulus, checked by a monitor.
module tb_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_start, host_abort, host_valid;
  logic [3:0]  host_len;
  logic [7:0]  host_data;
  logic        host_ready;
  logic [15:0] max_cycles;
  logic        core_write;
  logic [2:0]  core_addr;
  logic [7:0]  core_wdata;
  logic        core_reset, mem_write;
  logic [2:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy, done, timeout;
  logic [15:0] run_cycles;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  boot_ctrl dut (
    .clk(clk), .reset(reset), .host_start(host_start), .host_len(host_len),
    .host_abort(host_abort), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .max_cycles(max_cycles), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_reset(core_reset),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
  );

  // Monitor: every memory write must match the next queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && mem_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL mem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_wdata, e[10:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not complete, expected completion");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [3:0] len, input logic [15:0] mx);
    host_len   = len;
    max_cycles = mx;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  task automatic push_word(input logic [2:0] a, input logic [7:0] d);
    host_valid = 1'b1;
    host_data  = d;
    exp_q.push_back({a, d});
    tick();
    host_valid = 1'b0;
  endtask

  task automatic abort_once();
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_host_ready"}, host_ready, 0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_run_cycles"}, run_cycles, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; host_start = 0; host_abort = 0; host_valid = 0;
    host_len = 0; host_data = 0; max_cycles = 0;
    core_write = 0; core_addr = 0; core_wdata = 0;
    tick(); tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // load and run
    start(4'd3, 16'd0);
    check("load_busy", busy, 1);
    check("load_ready", host_ready, 1);
    check("load_core_reset", core_reset, 1);
    host_valid = 1'b1;
    host_data = 8'h21; exp_q.push_back({3'd0, 8'h21}); tick();
    host_data = 8'h05; exp_q.push_back({3'd1, 8'h05}); tick();
    host_data = 8'h40; exp_q.push_back({3'd2, 8'h40}); tick();
    host_valid = 1'b0;
    check("run_core_reset", core_reset, 0);
    check("run_busy", busy, 1);
    check("run_ready", host_ready, 0);
    start(4'd1, 16'd0);
    check("start_in_run_ignored", core_reset, 0);
    abort_once();
    check("abort_done", done, 1);

    // backpressure: valid 1,0,0,1
    start(4'd2, 16'd0);
    check("restart_done_clr", done, 0);
    push_word(3'd0, 8'hAA);
    tick(); tick();
    check("gap_still_load", host_ready, 1);
    push_word(3'd1, 8'hBB);
    check("bp_run", core_reset, 0);
    abort_once();

    // budget of 5 cycles with a core write passed through
    start(4'd0, 16'd5);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_reset) break;
      n++;
      if (i == 0) begin
        core_write = 1'b1; core_addr = 3'd5; core_wdata = 8'h77;
        exp_q.push_back({3'd5, 8'h77});
      end else begin
        core_write = 1'b0;
      end
      tick();
    end
    core_write = 1'b0;
    check("budget_cycles", n, 5);
    check("budget_done", done, 1);
    check("budget_timeout", timeout, 1);
    check("budget_run_cycles", run_cycles, 5);
    check("budget_busy", busy, 0);
    core_write = 1'b1; core_addr = 3'd3; core_wdata = 8'h5A;
    tick(); tick();
    core_write = 1'b0;

    // abort on the third RUN cycle, unlimited budget
    start(4'd0, 16'd0);
    check("abort_timeout_clr", timeout, 0);
    tick(); tick();
    abort_once();
    check("abort_halted", done, 1);
    check("abort_timeout", timeout, 0);
    check("abort_run_cycles", run_cycles, 2);
    abort_once();
    check("abort_in_halted_ignored", done, 1);
    start(4'd1, 16'd0);
    check("reload_done", done, 0);
    check("reload_busy", busy, 1);
    push_word(3'd0, 8'h3C);
    check("reload_run", core_reset, 0);
    abort_once();

    // length clamp
    start(4'd12, 16'd0);
    for (int i = 0; i < 8; i++) begin
      check("clamp_loading", host_ready, 1);
      push_word(3'(i), 8'(i + 8'h10));
    end
    check("clamp_run", core_reset, 0);
    abort_once();

    // reset mid-load
    start(4'd3, 16'd0);
    push_word(3'd0, 8'h11);
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    tick();
    start(4'd2, 16'd0);
    check("after_rst_ptr", mem_addr, 0);
    push_word(3'd0, 8'h99);
    push_word(3'd1, 8'h98);
    check("after_rst_run", core_reset, 0);
    abort_once();

    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
Name: boot_ctrl

Overview:
Boot and run controller for the accumulator core and its single-port data memory. It owns the memory operand port and the core's reset. It loads a program image from a host stream into memory while holding the core in reset, then hands the port to the core and releases it. It halts the core on host abort or when a cycle budget expires, and reports status back to the host.

Parameters:
word_width, 8, data word width; matches core and memory.
addr_width, $clog2(word_width), memory address width (localparam, derived); DEPTH = 2**addr_width.
cyc_width, 16, width of the run-cycle budget and counter.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
host_start  in  1  single-cycle pulse: begin load and run
host_len  in  addr_width+1  number of words to load; sampled with host_start
host_abort  in  1  single-cycle pulse: stop load or run
host_valid  in  1  host stream word valid
host_data  in  word_width  host stream word
host_ready  out  1  controller accepts host_data this cycle
max_cycles  in  cyc_width  run budget in cycles; 0 = unlimited; sampled with host_start
core_write  in  1  core write request
core_addr  in  addr_width  core operand address
core_wdata  in  word_width  core write data
core_reset  out  1  reset to core, active-high
mem_write  out  1  memory write enable
mem_addr  out  addr_width  memory operand address
mem_wdata  out  word_width  memory write data
busy  out  1  in LOAD or RUN
done  out  1  in HALTED
timeout  out  1  last halt caused by budget expiry
run_cycles  out  cyc_width  cycles spent in current or last RUN

Behaviour:
- Reset values: state IDLE; core_reset=1; host_ready=0; mem_write=0; mem_addr=0; mem_wdata=0; busy=0; done=0; timeout=0; run_cycles=0; load pointer 0.
- Reset mid-operation has priority over all inputs and returns every output to its reset value at that edge.
- States are IDLE, LOAD, RUN, HALTED. Outputs are decoded from the registered state.
- IDLE:
  - core_reset=1; memory port idle (mem_write=0).
  - On host_start: latch len = min(host_len, DEPTH) and latch max_cycles; clear pointer and run_cycles.
  - If len != 0, go to LOAD; if len == 0, go to RUN (executes existing memory contents).
- LOAD:
  - host_ready=1; core_reset=1.
  - mem_write = host_valid; mem_addr = pointer; mem_wdata = host_data. These are combinational, and memory samples them at the edge.
  - On host_valid, the pointer increments. On the edge accepting word len-1, go to RUN.
  - No write occurs while host_valid=0; the pointer holds.
  - host_abort: go to IDLE. Partial contents remain; done=0.
- RUN:
  - core_reset=0 from the first RUN cycle.
  - Memory port passes the core through (mem_write=core_write, mem_addr=core_addr, mem_wdata=core_wdata); host_ready=0.
  - run_cycles increments every RUN cycle and saturates at all-ones when max_cycles=0.
  - If max_cycles != 0 and run_cycles == max_cycles-1 at an edge: run_cycles becomes max_cycles, go to HALTED, timeout=1. The core therefore gets exactly max_cycles cycles with reset deasserted.
  - host_abort: go to HALTED with timeout=0. If abort and budget expiry coincide, timeout=1.
- HALTED:
  - core_reset=1; port idle; done=1; run_cycles and timeout held.
  - host_start: same as in IDLE. It clears done and timeout and re-latches len and max_cycles.
- host_start in LOAD or RUN is ignored. host_abort in IDLE or HALTED is ignored.
- busy=1 exactly in LOAD and RUN.

Decomposition:
- Package boot_pkg:
  - typedef enum logic [1:0] boot_state_t with IDLE=0, LOAD=1, RUN=2, HALTED=3.
  - localparam CYC_W=16.
- Sub-module run_watchdog: the cycle counter with enable, clear, saturation, budget compare, and expiry output. The main FSM and the port mux stay in boot_ctrl.

Test Plan:
- Load and run (word_width=8): start with host_len=3, host_valid held with data 0x21, 0x05, 0x40 → writes to addr 0, 1, 2 on three consecutive edges after entering LOAD; RUN on the next cycle; core_reset falls; busy=1.
- Backpressure: host_len=2, host_valid pattern 1,0,0,1 → exactly two writes (addr 0 then addr 1); no mem_write in gap cycles; RUN only after the second word.
- Budget: max_cycles=5 → exactly 5 cycles with core_reset=0, then HALTED with done=1, timeout=1, run_cycles=5, core_reset=1; core_write in HALTED does not reach mem_write.
- Abort: max_cycles=0, host_abort on the 3rd RUN cycle → HALTED with timeout=0, run_cycles=2. A following host_start with len=1 reloads and clears done.
- Length edges: host_len=12 → clamped, 8 writes to addr 0..7; host_len=0 → IDLE goes straight to RUN with no writes.
- Reset mid-LOAD after 1 word → all outputs at reset values next cycle; a subsequent start with len=2 loads from addr 0.
